// File: rtl/quad_decoder_pkg.sv
// -----------------------------------------------------------------------------
// quad_decoder_pkg
//   Shared definitions for the quadrature decoder:
//     - phase encoding of the {a,b} pin pair (PH_00..PH_10)
//     - step-delta codes seen when the accepted phase moves (delta_e)
//     - phase_of(): maps a Gray-coded pin pair to its position on the
//       4-phase cycle so that a step is simply a modulo-4 difference.
// -----------------------------------------------------------------------------
package quad_decoder_pkg;

    // Position of each pin pair on the quadrature cycle 00 -> 01 -> 11 -> 10
    localparam logic [1:0] PH_00 = 2'd0;
    localparam logic [1:0] PH_01 = 2'd1;
    localparam logic [1:0] PH_11 = 2'd2;
    localparam logic [1:0] PH_10 = 2'd3;

    // Modulo-4 phase difference between the new and the previously accepted pair
    typedef enum logic [1:0] {
        D_NONE = 2'd0,
        D_UP   = 2'd1,
        D_ILL  = 2'd2,
        D_DN   = 2'd3
    } delta_e;

    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = PH_00;
            2'b01:   ph = PH_01;
            2'b11:   ph = PH_11;
            2'b10:   ph = PH_10;
            default: ph = PH_00;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_decoder_if
//   Bundle of the decoder's pin inputs and position outputs.
//     enc_a, enc_b : quadrature phases from the pads (asynchronous)
//     clr          : synchronous clear of pos/pos_gray/err
//     pos          : binary position count
//     pos_gray     : Gray form of pos
//     step         : one-cycle pulse per accepted legal step
//     dir          : direction of the last step (1 = up)
//     err          : sticky illegal-transition flag
//   master: the side that drives pins/clr and observes the count.
//   slave : the decoder itself.
// -----------------------------------------------------------------------------
interface quad_decoder_if #(
    parameter int POS_BITS = 5
);
    logic                enc_a;
    logic                enc_b;
    logic                clr;
    logic [POS_BITS-1:0] pos;
    logic [POS_BITS-1:0] pos_gray;
    logic                step;
    logic                dir;
    logic                err;

    modport master (
        output enc_a, enc_b, clr,
        input  pos, pos_gray, step, dir, err
    );

    modport slave (
        input  enc_a, enc_b, clr,
        output pos, pos_gray, step, dir, err
    );
endinterface

// File: rtl/quad_decoder_sync_filter.sv
// -----------------------------------------------------------------------------
// quad_decoder_sync_filter
//   Synchroniser + stability filter + accepted-value register for a small
//   group of asynchronous pins.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     pins_i      : raw asynchronous pins
//     smp_o       : synchronised sample (output of the last sync flop)
//     acc_o       : last accepted value
//     accept_o    : high in the cycle whose clock edge accepts smp_o
//                   (acc_o takes smp_o at that edge)
//     primed_o    : at least one value has been accepted since reset
// -----------------------------------------------------------------------------
module quad_decoder_sync_filter #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LOG2   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] smp_o,
    output logic [WIDTH-1:0] acc_o,
    output logic             accept_o,
    output logic             primed_o
);

    localparam logic [FILT_LOG2-1:0] STAB_MAX = {FILT_LOG2{1'b1}};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [FILT_LOG2-1:0]              stab_q;
    logic [FILT_LOG2-1:0]              stab_d;
    logic [WIDTH-1:0]                  acc_q;
    logic                              primed_q;
    logic [WIDTH-1:0]                  smp_s;
    logic                              accept_s;

    assign smp_s = sync_q[SYNC_STAGES-1];

    // Stability counter next state and acceptance decision.
    // Acceptance also requires smp == prev: a saturated counter must not
    // let a value that only just appeared through unfiltered.
    always_comb begin
        stab_d   = stab_q;
        accept_s = 1'b0;
        if (smp_s != prev_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + FILT_LOG2'(1);
        end else begin
            stab_d = stab_q;
        end
        if ((stab_q == STAB_MAX) && (smp_s == prev_q) &&
            ((smp_s != acc_q) || !primed_q)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Synchroniser chain, filter state and accepted-value register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= '0;
            stab_q   <= '0;
            acc_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins_i};
            prev_q <= smp_s;
            stab_q <= stab_d;
            if (accept_s) begin
                acc_q    <= smp_s;
                primed_q <= 1'b1;
            end
        end
    end

    assign smp_o    = smp_s;
    assign acc_o    = acc_q;
    assign accept_o = accept_s;
    assign primed_o = primed_q;

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//   Decodes a 2-bit quadrature (Gray) pin pair into a wrapping up/down
//   position count and re-emits it in Gray form.
//   Ports:
//     clk : fabric clock
//     rst : asynchronous active-high reset
//     bus : quad_decoder_if.slave (enc_a/enc_b/clr in; pos/pos_gray/step/
//           dir/err out, all registered)
// -----------------------------------------------------------------------------
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int POS_BITS    = 5,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LOG2   = 4
) (
    input  logic             clk,
    input  logic             rst,
    quad_decoder_if.slave    bus
);

    logic [1:0]          smp_s;
    logic [1:0]          acc_s;
    logic                accept_s;
    logic                primed_s;
    delta_e              delta_s;

    logic [POS_BITS-1:0] pos_q,  pos_d;
    logic [POS_BITS-1:0] gray_q, gray_d;
    logic [POS_BITS-1:0] pos_step_s;
    logic                step_q, step_d;
    logic                dir_q,  dir_d;
    logic                err_q,  err_d;
    logic                err_step_s;

    quad_decoder_sync_filter #(
        .WIDTH       (2),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LOG2   (FILT_LOG2)
    ) u_sync_filter (
        .clk      (clk),
        .rst      (rst),
        .pins_i   ({bus.enc_a, bus.enc_b}),
        .smp_o    (smp_s),
        .acc_o    (acc_s),
        .accept_o (accept_s),
        .primed_o (primed_s)
    );

    assign delta_s = delta_e'(phase_of(smp_s) - phase_of(acc_s));

    // Step decode, clear override and Gray re-encoding of the next position.
    // The priming acceptance only loads acc inside the filter, so it is
    // excluded here by primed_s.
    always_comb begin
        pos_step_s = pos_q;
        err_step_s = err_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        if (accept_s && primed_s) begin
            case (delta_s)
                D_UP: begin
                    pos_step_s = pos_q + POS_BITS'(1);
                    dir_d      = 1'b1;
                    step_d     = 1'b1;
                end
                D_DN: begin
                    pos_step_s = pos_q - POS_BITS'(1);
                    dir_d      = 1'b0;
                    step_d     = 1'b1;
                end
                D_ILL: begin
                    err_step_s = 1'b1;
                end
                default: begin
                    pos_step_s = pos_q;
                end
            endcase
        end else begin
            step_d = 1'b0;
        end
        pos_d  = bus.clr ? '0   : pos_step_s;
        err_d  = bus.clr ? 1'b0 : err_step_s;
        gray_d = pos_d ^ (pos_d >> 1);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q  <= '0;
            gray_q <= '0;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            gray_q <= gray_d;
            step_q <= step_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    assign bus.pos      = pos_q;
    assign bus.pos_gray = gray_q;
    assign bus.step     = step_q;
    assign bus.dir      = dir_q;
    assign bus.err      = err_q;

endmodule
